// File: rtl/fetch_pack_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_pack_queue.
// slave: queue side (fetch in, decode out); master: the producer/consumer side.
interface fetch_pack_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid_i;
  logic [31:0]     in_instr_i;
  logic [PC_W-1:0] in_pc_i;
  logic            in_ready_o;
  logic            out_valid_o;
  logic [17:0]     out_instr_o;
  logic [PC_W-1:0] out_pc_o;
  logic            out_ready_i;
  logic            br_hint_o;
  logic [CW-1:0]   count_o;

  modport slave (
    input  in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_pc_o,
    output br_hint_o, count_o
  );

  modport master (
    output in_valid_i, in_instr_i, in_pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_pc_o,
    input  br_hint_o, count_o
  );
endinterface

// File: rtl/fetch_pack_queue.sv
// Packs 32-bit LEGv8 words into 18-bit decode words and queues them (DEPTH-entry FIFO).
// Ports: clk, reset (async high), flush_i (sync clear), bus (fetch_pack_queue_if.slave).
// Optional macro PREDECODE_BRANCH_EN stores a per-entry branch hint driving br_hint_o.
module fetch_pack_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  fetch_pack_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [17:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [17:0]     packed_w;
  logic            full;
  logic            push;
  logic            pop;
  logic            unused_bits;

  // Only opcode and Rd/cond fields survive packing.
  assign unused_bits = ^bus.in_instr_i[20:5];

  assign packed_w = {1'b0, bus.in_instr_i[4:0],
                     1'b0, bus.in_instr_i[31:21]};

  assign full = (count == CW'(DEPTH));
  assign bus.in_ready_o  = ~full & ~flush_i;
  assign bus.out_valid_o = (count != '0);
  assign push = bus.in_valid_i & bus.in_ready_o;
  assign pop  = bus.out_valid_o & bus.out_ready_i;

  assign bus.out_instr_o = mem_instr[rd_ptr];
  assign bus.out_pc_o    = mem_pc[rd_ptr];
  assign bus.count_o     = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= packed_w;
        mem_pc[wr_ptr]    <= bus.in_pc_i;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PREDECODE_BRANCH_EN
  logic mem_br [DEPTH];
  logic is_br;

  // B, BL, CBZ, B.cond, BR recognised on the packed opcode.
  always_comb begin
    is_br = 1'b0;
    unique case (1'b1)
      packed_w[10:5] == 6'b000101:       is_br = 1'b1;
      packed_w[10:5] == 6'b100101:       is_br = 1'b1;
      packed_w[10:3] == 8'b10110100:     is_br = 1'b1;
      packed_w[10:3] == 8'b01010100:     is_br = 1'b1;
      packed_w[10:0] == 11'b11010110000: is_br = 1'b1;
      default:                           is_br = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_br[i] <= 1'b0;
    end else if (!flush_i && push) begin
      mem_br[wr_ptr] <= is_br;
    end
  end

  assign bus.br_hint_o = bus.out_valid_o & mem_br[rd_ptr];
`else
  assign bus.br_hint_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pack_queue.sv
// Directed bench for fetch_pack_queue with a scoreboard queue.
// Checks handshake, ordering, wrap, flush, async reset and branch hint.
module tb_fetch_pack_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  typedef struct {
    logic [17:0] ins;
    logic [31:0] pc;
    logic        br;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   tests = 0;
  int   fails = 0;
  ent_t q[$];

  fetch_pack_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  fetch_pack_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] tpack(logic [31:0] w);
    logic [17:0] p;
    p = '0;
    p[10:0]  = w[31:21];
    p[16:12] = w[4:0];
    return p;
  endfunction

  function automatic logic tbr(logic [31:0] w);
`ifdef PREDECODE_BRANCH_EN
    return (w[31:26] == 6'b000101) || (w[31:26] == 6'b100101) ||
           (w[31:24] == 8'hB4) || (w[31:24] == 8'h54) ||
           (w[31:21] == 11'b11010110000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance it.
  task automatic cyc();
    bit   rdy, pushed, popped;
    ent_t e;
    @(negedge clk);
    rdy = (q.size() != DEPTH) && !flush;
    chk("in_ready", 64'(bus.in_ready_o), 64'(rdy));
    chk("out_valid", 64'(bus.out_valid_o), 64'(q.size() != 0));
    chk("count", 64'(bus.count_o), 64'(q.size()));
    if (q.size() != 0) begin
      chk("head_instr", 64'(bus.out_instr_o), 64'(q[0].ins));
      chk("head_pc", 64'(bus.out_pc_o), 64'(q[0].pc));
      chk("head_hint", 64'(bus.br_hint_o), 64'(q[0].br));
    end else begin
      chk("empty_hint", 64'(bus.br_hint_o), 64'd0);
    end
    pushed = bus.in_valid_i && rdy;
    popped = (q.size() != 0) && bus.out_ready_i;
    e.ins = tpack(bus.in_instr_i);
    e.pc  = bus.in_pc_i;
    e.br  = tbr(bus.in_instr_i);
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (popped) void'(q.pop_front());
      if (pushed) q.push_back(e);
    end
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] w, logic [31:0] pc,
                       logic rdy);
    bus.in_valid_i  = v;
    bus.in_instr_i  = w;
    bus.in_pc_i     = pc;
    bus.out_ready_i = rdy;
  endtask

  function automatic logic [31:0] wd(int i);
    return 32'h8B00_0000 + 32'(i) * 32'h0021_0003;
  endfunction

  task automatic check_zero(string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid_o), 64'd0);
    chk({tag, "_instr"}, 64'(bus.out_instr_o), 64'd0);
    chk({tag, "_pc"}, 64'(bus.out_pc_o), 64'd0);
    chk({tag, "_hint"}, 64'(bus.br_hint_o), 64'd0);
    chk({tag, "_count"}, 64'(bus.count_o), 64'd0);
    chk({tag, "_ready"}, 64'(bus.in_ready_o), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    check_zero("reset");
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: single ADD word
    drive(1'b1, 32'h8B020025, 32'h100, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    chk("t1_valid", 64'(bus.out_valid_o), 64'd1);
    chk("t1_instr", 64'(bus.out_instr_o), 64'h05458);
    chk("t1_pc", 64'(bus.out_pc_o), 64'h100);
    chk("t1_count", 64'(bus.count_o), 64'd1);
    chk("t1_hint", 64'(bus.br_hint_o), 64'd0);
    drive(1'b0, '0, '0, 1'b1);
    cyc();

    // 2: fill, hold fifth word, wrap
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, wd(i), 32'h200 + 32'(4 * i), 1'b0);
      cyc();
    end
    chk("t2_full", 64'(bus.in_ready_o), 64'd0);
    chk("t2_count", 64'(bus.count_o), 64'd4);
    drive(1'b1, wd(9), 32'h300, 1'b0);
    cyc();
    drive(1'b1, wd(9), 32'h300, 1'b1);
    cyc();
    drive(1'b1, wd(9), 32'h300, 1'b0);
    cyc();
    chk("t2_refill", 64'(bus.count_o), 64'd4);
    drive(1'b0, '0, '0, 1'b1);
    repeat (5) cyc();
    chk("t2_drained", 64'(bus.count_o), 64'd0);

    // 3: steady push+pop at count 2
    drive(1'b1, wd(20), 32'h400, 1'b0);
    cyc();
    drive(1'b1, wd(21), 32'h404, 1'b0);
    cyc();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, wd(22 + i), 32'h408 + 32'(4 * i), 1'b1);
      cyc();
    end
    chk("t3_count", 64'(bus.count_o), 64'd2);
    drive(1'b0, '0, '0, 1'b1);
    repeat (2) cyc();

    // 4: flush beats push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, wd(40 + i), 32'h500 + 32'(4 * i), 1'b0);
      cyc();
    end
    flush = 1'b1;
    drive(1'b1, wd(50), 32'h600, 1'b1);
    cyc();
    flush = 1'b0;
    chk("t4_count", 64'(bus.count_o), 64'd0);
    chk("t4_valid", 64'(bus.out_valid_o), 64'd0);
    drive(1'b1, wd(51), 32'h604, 1'b0);
    cyc();
    chk("t4_head", 64'(bus.out_pc_o), 64'h604);
    drive(1'b0, '0, '0, 1'b1);
    cyc();

    // 5: async reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, wd(60 + i), 32'h700 + 32'(4 * i), 1'b0);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_zero("t5_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    cyc();

    // 6: branch hints (B, CBZ, ADD, BR, B.cond, BL)
    drive(1'b1, 32'h14000004, 32'h800, 1'b0);
    cyc();
`ifdef PREDECODE_BRANCH_EN
    chk("t6_b_hint", 64'(bus.br_hint_o), 64'd1);
`else
    chk("t6_b_hint", 64'(bus.br_hint_o), 64'd0);
`endif
    chk("t6_b_op", 64'(bus.out_instr_o[10:5]), 64'b000101);
    drive(1'b1, 32'hB4000041, 32'h804, 1'b0);
    cyc();
    drive(1'b1, 32'h8B020025, 32'h808, 1'b0);
    cyc();
    drive(1'b1, 32'hD61F0000, 32'h80C, 1'b0);
    cyc();
    drive(1'b1, 32'h54000020, 32'h810, 1'b1);
    cyc();
    drive(1'b1, 32'h94000010, 32'h814, 1'b1);
    cyc();
    drive(1'b1, 32'hAA0103E2, 32'h818, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    repeat (6) cyc();
    chk("t6_empty", 64'(bus.count_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
